// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: data-bus request/response FSM and MEM/WB register
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : accesses whose byte offset is not a multiple of the access size
//               issue no bus request and do not stall. They retire with misalign=1
//               and no register write.
//   undefined : misalign is tied to 0. Misaligned accesses go to the bus, with the
//               strobe truncated at the 8-byte boundary.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   me_valid               ME-slot instruction valid
//   me_mem_read/_write     load / store
//   me_funct3              size+sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//   me_alu_result          effective address, or the result of a non-memory op
//   me_rs2_data            store data
//   me_rd_addr, me_rd_wen  destination register
//   req_*                  data-bus request channel (valid/ready handshake)
//   resp_valid, resp_rdata data-bus read response
//   mem_stall              holds the ME slot and all upstream stages
//   wb_*                   registered MEM/WB outputs
//   misalign               registered misaligned-access flag, valid with wb_valid
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_valid,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_funct3,
  input  logic [63:0] me_alu_result,
  input  logic [63:0] me_rs2_data,
  input  logic [4:0]  me_rd_addr,
  input  logic        me_rd_wen,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wstrb,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_wen,
  output logic [63:0] wb_rd_data,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic [63:0] load_data;

  logic        mem_op;
  logic [2:0]  off;
  logic        misaligned;
  logic        mis_access;
  logic [7:0]  size_mask;
  logic [63:0] shifted;
  logic [63:0] load_ext;

  assign mem_op = me_valid & (me_mem_read | me_mem_write);
  assign off    = me_alu_result[2:0];

  always_comb begin
    size_mask = 8'h01;
    case (me_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (me_funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // funct3 of a non-memory op is unrelated to size, so only a real access can be flagged.
  assign mis_access = mem_op & misaligned;

  // The ME slot is frozen by mem_stall, so the request fields below stay stable
  // from the ME inputs until the handshake completes.
  assign req_valid = ~rst & (state == REQ);
  assign req_wen   = me_mem_write;
  assign req_addr  = {me_alu_result[63:3], 3'b000};
  assign req_wdata = me_rs2_data << {off, 3'b000};
  assign req_wstrb = size_mask << off;

  // DONE is the release cycle: the writeback edge happens there.
  assign mem_stall = ~rst & mem_op & ~misaligned & (state != DONE);

  assign shifted = resp_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (me_funct3)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {56'b0, shifted[7:0]};
      3'b101:  load_ext = {48'b0, shifted[15:0]};
      3'b110:  load_ext = {32'b0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_data  <= '0;
      wb_valid   <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_wen  <= 1'b0;
      wb_rd_data <= '0;
      misalign   <= 1'b0;
    end else begin
      // resp_valid is only looked at in RESP, and RESP is entered on the
      // request handshake edge, so a response can never share that cycle.
      case (state)
        IDLE: if (mem_op && !misaligned) state <= REQ;
        REQ:  if (req_ready) state <= me_mem_read ? RESP : DONE;
        RESP: if (resp_valid) begin
                load_data <= load_ext;
                state     <= DONE;
              end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (mem_stall) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid   <= me_valid;
        wb_rd_addr <= me_rd_addr;
        wb_rd_wen  <= me_rd_wen & me_valid & ~mis_access;
        wb_rd_data <= (mem_op && me_mem_read && !misaligned) ? load_data : me_alu_result;
        misalign   <= mis_access;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_valid, me_mem_read, me_mem_write;
  logic [2:0]  me_funct3;
  logic [63:0] me_alu_result, me_rs2_data;
  logic [4:0]  me_rd_addr;
  logic        me_rd_wen;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_wen;
  logic [63:0] wb_rd_data;
  logic        misalign;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .me_valid(me_valid), .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_funct3(me_funct3), .me_alu_result(me_alu_result), .me_rs2_data(me_rs2_data),
    .me_rd_addr(me_rd_addr), .me_rd_wen(me_rd_wen),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_wen(wb_rd_wen),
    .wb_rd_data(wb_rd_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        mis;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [63:0] NOISE = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every writeback the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%h, expected no writeback",
                 wb_rd_addr, wb_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_wb_rd_addr"}, {59'b0, wb_rd_addr}, {59'b0, mon_e.rd});
        chk({mon_e.name, "_wb_rd_wen"}, {63'b0, wb_rd_wen}, {63'b0, mon_e.wen});
        chk({mon_e.name, "_misalign"}, {63'b0, misalign}, {63'b0, mon_e.mis});
        if (mon_e.chk_data) chk({mon_e.name, "_wb_rd_data"}, wb_rd_data, mon_e.data);
      end
    end
  end

  // Drives one instruction into the ME slot, plays the bus side and checks the
  // request fields and stall length. Expected writeback goes to the scoreboard.
  task automatic run_op(
    input string name, input logic rd_op, input logic wr_op, input logic [2:0] f3,
    input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd, input logic rdwen,
    input int rdy_dly, input int resp_dly, input logic [63:0] rdata,
    input logic exp_req, input logic [63:0] exp_addr, input logic [7:0] exp_wstrb,
    input logic [63:0] exp_wdata, input int exp_stall,
    input logic exp_wen, input logic [63:0] exp_data, input logic exp_mis, input logic chk_data);
    exp_t e;
    int   stall_cnt, reqcyc, respcyc;
    bit   accepted, saw_req, done;
    e.name = name; e.rd = rd; e.wen = exp_wen; e.data = exp_data;
    e.mis = exp_mis; e.chk_data = chk_data;
    exp_q.push_back(e);
    stall_cnt = 0; reqcyc = 0; respcyc = 0;
    accepted = 0; saw_req = 0; done = 0;
    me_valid = 1'b1; me_mem_read = rd_op; me_mem_write = wr_op; me_funct3 = f3;
    me_alu_result = alu; me_rs2_data = rs2; me_rd_addr = rd; me_rd_wen = rdwen;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = NOISE;
      if (!mem_stall) begin
        done = 1;
        resp_valid = 1'b1;
      end else begin
        stall_cnt++;
        if (stall_cnt > 1) chk({name, "_bubble"}, {63'b0, wb_valid}, 64'd0);
        if (req_valid) begin
          saw_req = 1;
          chk({name, "_req_addr"}, req_addr, exp_addr);
          chk({name, "_req_wstrb"}, {56'b0, req_wstrb}, {56'b0, exp_wstrb});
          chk({name, "_req_wdata"}, req_wdata, exp_wdata);
          chk({name, "_req_wen"}, {63'b0, req_wen}, {63'b0, wr_op});
          req_ready = (reqcyc >= rdy_dly);
          reqcyc++;
          resp_valid = 1'b1;
          if (req_ready) accepted = 1;
        end else if (accepted) begin
          if (respcyc >= resp_dly) begin
            resp_valid = 1'b1;
            resp_rdata = rdata;
          end
          respcyc++;
        end else begin
          resp_valid = 1'b1;
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got mem_stall stuck high, expected release within 60 cycles", name);
    end
    chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    chk({name, "_req_issued"}, {63'b0, saw_req}, {63'b0, exp_req});
    @(posedge clk); #1;
    me_valid = 1'b0; me_mem_read = 1'b0; me_mem_write = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_funct3 = 3'b011;
    me_alu_result = 64'h1000; me_rs2_data = '0; me_rd_addr = 5'd3; me_rd_wen = 1'b1;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'b0, req_valid}, 64'd0);
    chk("rst_mem_stall", {63'b0, mem_stall}, 64'd0);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rst_wb_rd_wen", {63'b0, wb_rd_wen}, 64'd0);
    chk("rst_misalign", {63'b0, misalign}, 64'd0);
    chk("rst_wb_rd_addr", {59'b0, wb_rd_addr}, 64'd0);
    chk("rst_wb_rd_data", wb_rd_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; me_valid = 1'b0; me_mem_read = 1'b0;

    //      name       rd wr f3      alu                    rs2                    rd     wen rdy rsp rdata
    //      req addr                  wstrb  wdata                   stall wen data                   mis chk
    run_op("add",      0, 0, 3'b000, 64'h1234,              64'h0,                 5'd5,  1, 0, 0, 64'h0,
           0, 64'h0,                  8'h00, 64'h0,                  0,    1, 64'h1234,              0, 1);
    run_op("alu_odd",  0, 0, 3'b001, 64'hFFFF_0000_0000_0001, 64'h0,               5'd31, 1, 0, 0, 64'h0,
           0, 64'h0,                  8'h00, 64'h0,                  0,    1, 64'hFFFF_0000_0000_0001, 0, 1);
    run_op("lb",       1, 0, 3'b000, 64'h1003,              64'h0,                 5'd6,  1, 0, 0, 64'h0000_0000_8000_0000,
           1, 64'h1000,               8'h08, 64'h0,                  3,    1, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    run_op("sh",       0, 1, 3'b001, 64'h2006,              64'hABCD,              5'd0,  0, 4, 0, 64'h0,
           1, 64'h2000,               8'hC0, 64'hABCD_0000_0000_0000, 6,   0, 64'h2006,              0, 1);
    run_op("lwu",      1, 0, 3'b110, 64'h3004,              64'h0,                 5'd8,  1, 0, 0, 64'hFFFF_FFFF_0000_0000,
           1, 64'h3000,               8'hF0, 64'h0,                  3,    1, 64'h0000_0000_FFFF_FFFF, 0, 1);
    run_op("lw_slow",  1, 0, 3'b010, 64'h7000,              64'h0,                 5'd9,  1, 1, 2, 64'h0000_0000_8000_0001,
           1, 64'h7000,               8'h0F, 64'h0,                  6,    1, 64'hFFFF_FFFF_8000_0001, 0, 1);
    run_op("lbu",      1, 0, 3'b100, 64'h1007,              64'h0,                 5'd10, 1, 0, 0, 64'hA500_0000_0000_0000,
           1, 64'h1000,               8'h80, 64'h0,                  3,    1, 64'h0000_0000_0000_00A5, 0, 1);
    run_op("lhu",      1, 0, 3'b101, 64'h3006,              64'h0,                 5'd11, 1, 0, 0, 64'h8001_0000_0000_0000,
           1, 64'h3000,               8'hC0, 64'h0,                  3,    1, 64'h0000_0000_0000_8001, 0, 1);
    run_op("sd",       0, 1, 3'b011, 64'h8000,              64'h0123_4567_89AB_CDEF, 5'd0, 0, 0, 0, 64'h0,
           1, 64'h8000,               8'hFF, 64'h0123_4567_89AB_CDEF, 2,   0, 64'h8000,              0, 1);
    run_op("sb",       0, 1, 3'b000, 64'h8003,              64'h1234,              5'd0,  0, 0, 0, 64'h0,
           1, 64'h8000,               8'h08, 64'h0000_0012_3400_0000, 2,   0, 64'h8003,              0, 1);
    run_op("lh_align", 1, 0, 3'b001, 64'h5002,              64'h0,                 5'd14, 1, 0, 0, 64'h0000_0000_1234_0000,
           1, 64'h5000,               8'h0C, 64'h0,                  3,    1, 64'h0000_0000_0000_1234, 0, 1);
`ifdef MEM_MISALIGN_CHECK_EN
    run_op("ld_mis",   1, 0, 3'b011, 64'h4004,              64'h0,                 5'd12, 1, 0, 0, 64'h1122_3344_5566_7788,
           0, 64'h0,                  8'h00, 64'h0,                  0,    0, 64'h0,                 1, 0);
    run_op("lh_mis",   1, 0, 3'b001, 64'h5001,              64'h0,                 5'd13, 1, 0, 0, 64'h0000_0000_00AB_CD00,
           0, 64'h0,                  8'h00, 64'h0,                  0,    0, 64'h0,                 1, 0);
    run_op("sw_mis",   0, 1, 3'b010, 64'h6006,              64'h1122_3344,         5'd0,  0, 0, 0, 64'h0,
           0, 64'h0,                  8'h00, 64'h0,                  0,    0, 64'h0,                 1, 0);
`else
    run_op("ld_mis",   1, 0, 3'b011, 64'h4004,              64'h0,                 5'd12, 1, 0, 0, 64'h1122_3344_5566_7788,
           1, 64'h4000,               8'hF0, 64'h0,                  3,    1, 64'h0000_0000_1122_3344, 0, 1);
    run_op("lh_mis",   1, 0, 3'b001, 64'h5001,              64'h0,                 5'd13, 1, 0, 0, 64'h0000_0000_00AB_CD00,
           1, 64'h5000,               8'h06, 64'h0,                  3,    1, 64'hFFFF_FFFF_FFFF_ABCD, 0, 1);
    run_op("sw_mis",   0, 1, 3'b010, 64'h6006,              64'h1122_3344,         5'd0,  0, 0, 0, 64'h0,
           1, 64'h6000,               8'hC0, 64'h3344_0000_0000_0000, 2,   0, 64'h6006,              0, 1);
`endif

    // Reset while waiting for a load response; the late response must be dropped.
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_funct3 = 3'b011;
    me_alu_result = 64'h9000; me_rs2_data = '0; me_rd_addr = 5'd7; me_rd_wen = 1'b1;
    @(negedge clk);
    chk("rstmid_idle_stall", {63'b0, mem_stall}, 64'd1);
    @(negedge clk);
    chk("rstmid_req_valid", {63'b0, req_valid}, 64'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("rstmid_resp_stall", {63'b0, mem_stall}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_req_valid_in_rst", {63'b0, req_valid}, 64'd0);
    chk("rstmid_stall_in_rst", {63'b0, mem_stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; me_valid = 1'b0; me_mem_read = 1'b0;
    @(negedge clk);
    chk("rstmid_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rstmid_wb_rd_wen", {63'b0, wb_rd_wen}, 64'd0);
    resp_valid = 1'b1; resp_rdata = NOISE;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("rstmid_late_resp_stall", {63'b0, mem_stall}, 64'd0);
    chk("rstmid_late_resp_req", {63'b0, req_valid}, 64'd0);
    chk("rstmid_late_resp_wb_valid", {63'b0, wb_valid}, 64'd0);
    @(posedge clk); #1;

    run_op("add_post", 0, 0, 3'b000, 64'h55,                64'h0,                 5'd2,  1, 0, 0, 64'h0,
           0, 64'h0,                  8'h00, 64'h0,                  0,    1, 64'h55,                0, 1);
    run_op("lb_post",  1, 0, 3'b000, 64'hA001,              64'h0,                 5'd4,  1, 0, 0, 64'h0000_0000_0000_7F00,
           1, 64'hA000,               8'h02, 64'h0,                  3,    1, 64'h0000_0000_0000_007F, 0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
